// File: rtl/spi_slave_gen.sv
// -----------------------------------------------------------------------------
// spi_slave_gen
//
// Purpose
//   SPI slave front end for a small command/memory protocol. One frame is
//   framed by SS_n low. The first bit chooses between a write frame and the two
//   read phases. The frame carries {cmd[1:0], payload[DW-1:0]} MSB first. It is
//   followed by one even-parity bit when SPI_SLAVE_PARITY_EN is defined.
//   All SPI signals are sampled once per rising edge of clk (no SCLK domain).
//
//   Frame kinds, selected by the first command bit and the rd_addr_done flag:
//     first bit 0                      -> WRITE     (rx_valid with the frame)
//     first bit 1, no address pending  -> READ_ADD  (rx_valid, sets rd_addr_done)
//     first bit 1, address pending     -> READ_DATA (rx_valid, then waits for
//                                          tx_valid and shifts tx_data out)
//
// Configuration
//   SPI_SLAVE_PARITY_EN  when defined, a trailing even-parity bit is expected
//                        after the DW+CW data bits. On mismatch, rx_valid is
//                        suppressed and parity_err pulses. When undefined,
//                        parity_err is tied to 0.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   SS_n       in   slave select, active low, frames one transaction
//   MOSI       in   serial data in, MSB first
//   MISO       out  serial data out, MSB first, 0 when not transmitting
//   rx_data    out  [DW+CW-1:0] last accepted frame {cmd, payload}
//   rx_valid   out  one-cycle strobe, rx_data valid in that cycle
//   tx_data    in   [DW-1:0] read data from the memory side
//   tx_valid   in   tx_data valid (see handshake note below)
//   frame_err  out  one-cycle strobe when a frame is aborted by SS_n
//   parity_err out  one-cycle strobe on parity mismatch
//   fsm_state  out  [2:0] current FSM state, for observation only
//
// Handshake
//   tx_valid/tx_data have no ready. They are looked at only while a READ_DATA
//   frame is waiting after its rx_valid pulse. The first cycle with
//   tx_valid=1 captures tx_data, and MISO starts on the following cycle. At
//   all other times tx_valid is ignored, so the memory side may hold it high.
// -----------------------------------------------------------------------------
module spi_slave_gen #(
  parameter int DW = 8,
  parameter int CW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [DW+CW-1:0]     rx_data,
  output logic                 rx_valid,
  input  logic [DW-1:0]        tx_data,
  input  logic                 tx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic [2:0]           fsm_state
);

  // Data bits per frame, and total serial bits per frame.
  localparam int FW = DW + CW;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int FL = FW + 1;
`else
  localparam int FL = FW;
`endif

  // The counter can hold FL without wrapping, even with parity enabled.
  localparam int CNT_W = $clog2(DW + CW + 2);

  // The shift register holds every bit except the last one of the frame.
  // Without parity, the last serial bit is the payload LSB and is merged on
  // the fly. With parity, the last bit is the parity bit and is never stored.
  localparam int SR_W = FL - 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FL - 1);
  localparam logic [CNT_W-1:0] TX_BITS  = CNT_W'(DW);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // FSM states
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  // Sub-phase inside WRITE / READ_ADD / READ_DATA.
  //   PH_RX   : shifting in frame bits (an SS_n rise here is an abort)
  //   PH_WAIT : READ_DATA only, waiting for tx_valid (no timeout)
  //   PH_TX   : READ_DATA only, shifting tx_data out (an SS_n rise is an abort)
  //   PH_DONE : frame finished, MOSI ignored until SS_n rises
  localparam logic [1:0] PH_RX   = 2'd0;
  localparam logic [1:0] PH_WAIT = 2'd1;
  localparam logic [1:0] PH_TX   = 2'd2;
  localparam logic [1:0] PH_DONE = 2'd3;

  logic [2:0]      state;
  logic [1:0]      phase;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0] shreg;
  logic [DW-1:0]   tx_sh;
  logic            rd_addr_done;
  // Set once SS_n has been seen high after reset. A slave select held low
  // through reset therefore does not start a frame.
  logic            armed;

  logic            last_bit;
  logic            frame_ok;
  logic [FW-1:0]   rx_next;

  assign fsm_state = state;
  assign last_bit  = (cnt == LAST_BIT);

`ifdef SPI_SLAVE_PARITY_EN
  // Running XOR of the data bits. Even parity means that data XOR the parity
  // bit must be 0.
  logic par_acc;
  assign frame_ok = ~(par_acc ^ MOSI);
  assign rx_next  = shreg;
`else
  assign frame_ok = 1'b1;
  assign rx_next  = {shreg, MOSI};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= PH_RX;
      cnt          <= '0;
      shreg        <= '0;
      tx_sh        <= '0;
      rd_addr_done <= 1'b0;
      armed        <= 1'b0;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      par_acc      <= 1'b0;
`endif
    end else begin
      // Strobes default low, so each one lasts exactly one cycle.
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      if (SS_n) begin
        armed <= 1'b1;
      end

      if (state == IDLE) begin
        MISO <= 1'b0;
        cnt  <= '0;
        if (!SS_n && armed) begin
          state <= CHK_CMD;
          phase <= PH_RX;
        end
      end else if (SS_n) begin
        // Deselect from any active state returns to IDLE. It counts as an
        // abort only while bits are still being received or transmitted.
        // rd_addr_done is left untouched.
        state <= IDLE;
        MISO  <= 1'b0;
        cnt   <= '0;
        if ((phase == PH_RX) || (phase == PH_TX)) begin
          frame_err <= 1'b1;
        end
      end else if (state == CHK_CMD) begin
        // The first bit is the command MSB. Start a fresh shift register.
        shreg <= {{(SR_W-1){1'b0}}, MOSI};
        cnt   <= CNT_ONE;
`ifdef SPI_SLAVE_PARITY_EN
        par_acc <= MOSI;
`endif
        if (!MOSI) begin
          state <= WRITE;
        end else if (rd_addr_done) begin
          state <= READ_DATA;
        end else begin
          state <= READ_ADD;
        end
      end else begin
        case (phase)
          PH_RX: begin
            cnt <= cnt + 1'b1;
            if (cnt < LAST_BIT) begin
              shreg <= {shreg[SR_W-2:0], MOSI};
`ifdef SPI_SLAVE_PARITY_EN
              par_acc <= par_acc ^ MOSI;
`endif
            end
            if (last_bit) begin
`ifdef SPI_SLAVE_PARITY_EN
              if (frame_ok) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                if (state == READ_ADD) begin
                  rd_addr_done <= 1'b1;
                end
                phase <= (state == READ_DATA) ? PH_WAIT : PH_DONE;
              end else begin
                // Bad frame: no data, no side effects, wait for deselect.
                parity_err <= 1'b1;
                phase      <= PH_DONE;
              end
`else
              rx_data  <= rx_next;
              rx_valid <= frame_ok;
              if (state == READ_ADD) begin
                rd_addr_done <= 1'b1;
              end
              phase <= (state == READ_DATA) ? PH_WAIT : PH_DONE;
`endif
            end
          end

          PH_WAIT: begin
            if (tx_valid) begin
              MISO  <= tx_data[DW-1];
              tx_sh <= {tx_data[DW-2:0], 1'b0};
              cnt   <= CNT_ONE;
              phase <= PH_TX;
            end
          end

          PH_TX: begin
            if (cnt == TX_BITS) begin
              // The last bit has been on MISO for its full cycle.
              MISO         <= 1'b0;
              rd_addr_done <= 1'b0;
              phase        <= PH_DONE;
            end else begin
              MISO  <= tx_sh[DW-1];
              tx_sh <= {tx_sh[DW-2:0], 1'b0};
              cnt   <= cnt + 1'b1;
            end
          end

          default: begin
            // PH_DONE: ignore MOSI until SS_n rises.
            MISO <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_gen.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_gen
//
// Directed bench for spi_slave_gen. There are two instances: DW=8 for most
// scenarios and DW=16 for the wide-payload frame. Inputs change 1 time unit
// after each rising edge. Outputs are sampled at the same point, so they show
// what the edge just registered.
// -----------------------------------------------------------------------------
module tb_spi_slave_gen;

  localparam int FW = 10;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAST_IDX = FW - 1 + PB;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_READ_ADD  = 3'd3;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_READ_DATA = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DW=8 instance
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        miso;
  logic [9:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        parity_err;
  logic [2:0]  fsm_state;

  // DW=16 instance
  logic        ss_n16 = 1'b1;
  logic        mosi16 = 1'b0;
  logic        tx_valid16 = 1'b0;
  logic [15:0] tx_data16 = 16'h0000;
  logic        miso16;
  logic [17:0] rx_data16;
  logic        rx_valid16;
  logic        frame_err16;
  logic        parity_err16;
  logic [2:0]  fsm_state16;

  spi_slave_gen #(.DW(8), .CW(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .SS_n       (ss_n),
    .MOSI       (mosi),
    .MISO       (miso),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .fsm_state  (fsm_state)
  );

  spi_slave_gen #(.DW(16), .CW(2)) u_dut16 (
    .clk        (clk),
    .rst        (rst),
    .SS_n       (ss_n16),
    .MOSI       (mosi16),
    .MISO       (miso16),
    .rx_data    (rx_data16),
    .rx_valid   (rx_valid16),
    .tx_data    (tx_data16),
    .tx_valid   (tx_valid16),
    .frame_err  (frame_err16),
    .parity_err (parity_err16),
    .fsm_state  (fsm_state16)
  );

  int checks = 0;
  int errors = 0;

  // Monitor results collected by the driver tasks.
  int         mon_pulses;
  int         mon_pulse_at;
  int         mon_ferr;
  int         mon_perr;
  logic       mon_miso;
  logic [9:0] mon_rx;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_pulses   = 0;
    mon_pulse_at = -1;
    mon_ferr     = 0;
    mon_perr     = 0;
    mon_miso     = 1'b0;
    mon_rx       = '0;
  endtask

  task automatic deselect();
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();
  endtask

  // IDLE sees SS_n low on this edge; the first bit follows.
  task automatic select();
    ss_n = 1'b0;
    mosi = 1'b0;
    tick();
  endtask

  task automatic drive_bit(input logic b, input int idx);
    mosi = b;
    tick();
    if (rx_valid === 1'b1) begin
      mon_pulses++;
      mon_pulse_at = idx;
      mon_rx = rx_data;
    end
    if (frame_err === 1'b1) mon_ferr++;
    if (parity_err === 1'b1) mon_perr++;
    if (miso !== 1'b0) mon_miso = 1'b1;
  endtask

  // Sends a whole frame MSB first. flip inverts the parity bit when parity
  // is enabled.
  task automatic send_frame(input logic [9:0] frame, input logic flip);
    clear_mon();
    select();
    for (int i = FW - 1; i >= 0; i--) drive_bit(frame[i], FW - 1 - i);
`ifdef SPI_SLAVE_PARITY_EN
    drive_bit((^frame) ^ flip, FW);
`else
    if (flip) $display("note: parity flip ignored without parity");
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    ss_n = 1'b0;   // held low through reset: must not start a frame
    #1;
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
    checks++; if (rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data: got %h expected 000", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0 || parity_err !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b expected 00", frame_err, parity_err); end
    checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
    checks++; if (rx_data16 !== 18'h0) begin errors++; $display("FAIL reset_rx_data16: got %h expected 00000", rx_data16); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_needs_ss_high: got state %0d expected 0", fsm_state); end
    deselect();
  endtask

  task automatic test_write();
    send_frame(10'b00_1010_0101, 1'b0);
    checks++; if (mon_pulses != 1) begin errors++; $display("FAIL write_pulses: got %0d expected 1", mon_pulses); end
    checks++; if (mon_pulse_at != LAST_IDX) begin errors++; $display("FAIL write_pulse_bit: got %0d expected %0d", mon_pulse_at, LAST_IDX); end
    checks++; if (mon_rx !== 10'h0A5) begin errors++; $display("FAIL write_rx_data: got %h expected 0a5", mon_rx); end
    checks++; if (mon_ferr != 0 || mon_perr != 0) begin errors++; $display("FAIL write_errs: got %0d/%0d expected 0/0", mon_ferr, mon_perr); end
    checks++; if (fsm_state !== S_WRITE) begin errors++; $display("FAIL write_state: got %0d expected 2", fsm_state); end
    // Extra bits after completion are ignored.
    clear_mon();
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 2);
    checks++; if (mon_pulses != 0 || rx_data !== 10'h0A5) begin errors++; $display("FAIL write_extra_bits: got %0d pulses rx %h expected 0 pulses rx 0a5", mon_pulses, rx_data); end
    deselect();
    checks++; if (frame_err !== 1'b0 || fsm_state !== S_IDLE) begin errors++; $display("FAIL write_end: got ferr %b state %0d expected 0 0", frame_err, fsm_state); end
  endtask

  task automatic test_back_to_back();
    send_frame(10'b00_1111_0000, 1'b0);
    checks++; if (mon_pulses != 1 || mon_rx !== 10'h0F0) begin errors++; $display("FAIL b2b_first: got %0d pulses rx %h expected 1 pulse rx 0f0", mon_pulses, mon_rx); end
    deselect();
    send_frame(10'b01_0000_1111, 1'b0);
    checks++; if (mon_pulses != 1 || mon_rx !== 10'h10F) begin errors++; $display("FAIL b2b_second: got %0d pulses rx %h expected 1 pulse rx 10f", mon_pulses, mon_rx); end
    deselect();
  endtask

  task automatic test_read();
    logic [7:0] got;
    int         miso_hi;
    // tx_valid held high during the address frame must be ignored.
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    send_frame(10'b10_0011_0000, 1'b0);
    checks++; if (mon_pulses != 1 || mon_rx !== 10'h230) begin errors++; $display("FAIL read_addr_rx: got %0d pulses rx %h expected 1 pulse rx 230", mon_pulses, mon_rx); end
    checks++; if (fsm_state !== S_READ_ADD) begin errors++; $display("FAIL read_addr_state: got %0d expected 3", fsm_state); end
    checks++; if (mon_miso !== 1'b0 || miso !== 1'b0) begin errors++; $display("FAIL read_addr_miso_quiet: got %b expected 0", mon_miso | miso); end
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    deselect();
    send_frame(10'b11_0000_0000, 1'b0);
    checks++; if (mon_pulses != 1 || mon_rx !== 10'h300) begin errors++; $display("FAIL read_data_rx: got %0d pulses rx %h expected 1 pulse rx 300", mon_pulses, mon_rx); end
    checks++; if (fsm_state !== S_READ_DATA) begin errors++; $display("FAIL read_data_state: got %0d expected 4", fsm_state); end
    miso_hi = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (miso !== 1'b0) miso_hi++;
    end
    checks++; if (miso_hi != 0) begin errors++; $display("FAIL read_wait_miso: got %0d high cycles expected 0", miso_hi); end
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      got[7-i] = miso;
      tick();
    end
    checks++; if (got !== 8'h3C) begin errors++; $display("FAIL read_miso_seq: got %b expected 00111100", got); end
    checks++; if (miso !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL read_miso_after: got miso %b ferr %b expected 0 0", miso, frame_err); end
    deselect();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL read_end_ferr: got %b expected 0", frame_err); end
    // rd_addr_done cleared: the next read goes to READ_ADD.
    select();
    mosi = 1'b1;
    tick();
    checks++; if (fsm_state !== S_READ_ADD) begin errors++; $display("FAIL read_done_cleared: got %0d expected 3", fsm_state); end
    deselect();
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL read_partial_abort: got %b expected 1", frame_err); end
  endtask

  task automatic test_abort_write();
    logic [9:0] f;
    f = 10'b00_1010_0101;
    clear_mon();
    select();
    for (int i = 0; i < 5; i++) drive_bit(f[9-i], i);
    ss_n = 1'b1;
    tick();
    checks++; if (frame_err !== 1'b1 || rx_valid !== 1'b0) begin errors++; $display("FAIL abort5_strobes: got ferr %b rxv %b expected 1 0", frame_err, rx_valid); end
    checks++; if (fsm_state !== S_IDLE || mon_pulses != 0) begin errors++; $display("FAIL abort5_state: got state %0d pulses %0d expected 0 0", fsm_state, mon_pulses); end
    tick();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL abort5_one_cycle: got %b expected 0", frame_err); end
  endtask

  task automatic test_abort_last_bit();
    logic [9:0] f;
    f = 10'b00_1100_0011;
    clear_mon();
    select();
    for (int i = 0; i < LAST_IDX; i++) drive_bit(f[9-i], i);
    // Final bit arrives together with the deselect.
`ifdef SPI_SLAVE_PARITY_EN
    mosi = ^f;
`else
    mosi = f[0];
`endif
    ss_n = 1'b1;
    tick();
    checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b1 || mon_pulses != 0) begin errors++; $display("FAIL abort_last_bit: got rxv %b ferr %b pulses %0d expected 0 1 0", rx_valid, frame_err, mon_pulses); end
    deselect();
  endtask

  task automatic test_tx_abort();
    logic [7:0] got;
    send_frame(10'b10_0000_0001, 1'b0);
    deselect();
    send_frame(10'b11_0000_0001, 1'b0);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    ss_n = 1'b1;
    tick();
    checks++; if (frame_err !== 1'b1 || miso !== 1'b0 || fsm_state !== S_IDLE) begin errors++; $display("FAIL tx_abort: got ferr %b miso %b state %0d expected 1 0 0", frame_err, miso, fsm_state); end
    // rd_addr_done survives the abort: a full read-data frame follows.
    send_frame(10'b11_0101_0101, 1'b0);
    checks++; if (fsm_state !== S_READ_DATA || mon_rx !== 10'h355) begin errors++; $display("FAIL tx_abort_keeps_addr: got state %0d rx %h expected 4 355", fsm_state, mon_rx); end
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got[7-i] = miso;
      tick();
    end
    checks++; if (got !== 8'h81 || miso !== 1'b0) begin errors++; $display("FAIL tx_retry_seq: got %h miso %b expected 81 0", got, miso); end
    deselect();
  endtask

  task automatic test_tx_reset();
    send_frame(10'b10_0000_0010, 1'b0);
    deselect();
    send_frame(10'b11_0000_0010, 1'b0);
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    tick();               // first MISO bit now showing
    tx_valid = 1'b0;
    tick();
    tick();
    tick();               // fourth bit (bit 4 of F0 = 1)
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL txrst_fourth_bit: got %b expected 1", miso); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (miso !== 1'b0 || fsm_state !== S_IDLE) begin errors++; $display("FAIL txrst_immediate: got miso %b state %0d expected 0 0", miso, fsm_state); end
    checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin errors++; $display("FAIL txrst_strobes: got %b%b%b expected 000", rx_valid, frame_err, parity_err); end
    ss_n = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (frame_err !== 1'b0 || miso !== 1'b0) begin errors++; $display("FAIL txrst_after: got ferr %b miso %b expected 0 0", frame_err, miso); end
    select();
    mosi = 1'b1;
    tick();
    checks++; if (fsm_state !== S_READ_ADD) begin errors++; $display("FAIL txrst_next_read: got %0d expected 3", fsm_state); end
    deselect();
  endtask

  task automatic test_parity();
`ifdef SPI_SLAVE_PARITY_EN
    send_frame(10'h001, 1'b1);   // parity bit 0: mismatch
    checks++; if (mon_perr != 1 || mon_pulses != 0) begin errors++; $display("FAIL parity_bad: got perr %0d pulses %0d expected 1 0", mon_perr, mon_pulses); end
    deselect();
    send_frame(10'h001, 1'b0);   // parity bit 1: accepted
    checks++; if (mon_perr != 0 || mon_pulses != 1 || mon_rx !== 10'h001) begin errors++; $display("FAIL parity_good: got perr %0d pulses %0d rx %h expected 0 1 001", mon_perr, mon_pulses, mon_rx); end
    deselect();
`else
    send_frame(10'h001, 1'b0);
    checks++; if (mon_perr != 0 || mon_pulses != 1 || mon_rx !== 10'h001) begin errors++; $display("FAIL noparity_frame: got perr %0d pulses %0d rx %h expected 0 1 001", mon_perr, mon_pulses, mon_rx); end
    deselect();
`endif
  endtask

  task automatic test_dw16();
    logic [17:0] f;
    logic [17:0] got;
    int          pulses;
    int          at;
    f = {2'b00, 16'hBEEF};
    got = '0;
    pulses = 0;
    at = -1;
    ss_n16 = 1'b0;
    mosi16 = 1'b0;
    tick();
    for (int i = 17; i >= 0; i--) begin
      mosi16 = f[i];
      tick();
      if (rx_valid16 === 1'b1) begin pulses++; at = 17 - i; got = rx_data16; end
    end
`ifdef SPI_SLAVE_PARITY_EN
    mosi16 = ^f;
    tick();
    if (rx_valid16 === 1'b1) begin pulses++; at = 18; got = rx_data16; end
`endif
    checks++; if (pulses != 1 || at != 17 + PB) begin errors++; $display("FAIL dw16_pulse: got %0d pulses at %0d expected 1 at %0d", pulses, at, 17 + PB); end
    checks++; if (got !== 18'h0BEEF) begin errors++; $display("FAIL dw16_rx_data: got %h expected 0beef", got); end
    ss_n16 = 1'b1;
    mosi16 = 1'b0;
    tick();
    checks++; if (frame_err16 !== 1'b0 || fsm_state16 !== S_IDLE) begin errors++; $display("FAIL dw16_end: got ferr %b state %0d expected 0 0", frame_err16, fsm_state16); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_read();
    test_abort_write();
    test_abort_last_bit();
    test_tx_abort();
    test_tx_reset();
    test_parity();
    test_dw16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_gen.md
SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Interface
REQ-001 SHALL provide parameter DW, default 8: payload width in bits, legal range 4..32.
REQ-002 SHALL provide parameter CW, default 2: command-field width in bits, fixed at 2.
REQ-003 clk  input  1  Single system clock; all logic on rising edge; SPI bits are sampled once per clk.
REQ-004 rst  input  1  Reset, asynchronous and active-high.
REQ-005 SS_n  input  1  Slave select, active low; frames one transaction.
REQ-006 MOSI  input  1  Serial data in, MSB first.
REQ-007 MISO  output  1  Serial data out, MSB first.
REQ-008 rx_data  output  DW+CW  Received frame {cmd[1:0], payload[DW-1:0]}.
REQ-009 rx_valid  output  1  One-cycle strobe; rx_data is valid in that cycle.
REQ-010 tx_data  input  DW  Read data from the memory side.
REQ-011 tx_valid  input  1  tx_data is valid; sampled only in READ_DATA wait sub-phase.
REQ-012 frame_err  output  1  One-cycle strobe on aborted frame.
REQ-013 parity_err  output  1  One-cycle strobe on parity mismatch; tied 0 when parity is compiled out.

Function
REQ-014 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-015 IDLE -> CHK_CMD on SS_n=0; otherwise stay in IDLE.
REQ-016 In CHK_CMD, the MOSI bit SHALL be stored as rx_data MSB and the bit counter set to 1.
REQ-017 CHK_CMD exit: MOSI=0 -> WRITE; MOSI=1 with rd_addr_done=0 -> READ_ADD; MOSI=1 with rd_addr_done=1 -> READ_DATA.
REQ-018 In every non-IDLE state, SS_n=1 SHALL force IDLE on the next edge.
REQ-019 Each following cycle SHALL shift one MOSI bit MSB-first into a shift register until the counter reaches FL, where FL=DW+CW (+1 with parity).
REQ-020 On the cycle the counter reaches FL, rx_data SHALL update and rx_valid SHALL pulse exactly one cycle.
REQ-021 After the pulse, further MOSI bits SHALL be ignored until SS_n=1.
REQ-022 A completed READ_ADD frame SHALL set rd_addr_done.
REQ-023 READ_DATA, after its rx_valid pulse, SHALL wait with no timeout for tx_valid=1.
REQ-024 On the first cycle with tx_valid=1, tx_data SHALL be captured; MISO SHALL present bit DW-1 on the next cycle, then one bit per cycle for DW cycles.
REQ-025 After the last MISO bit, rd_addr_done SHALL clear and MISO SHALL return to 0.
REQ-026 MISO SHALL be 0 whenever it is not transmitting.
REQ-027 tx_valid outside the READ_DATA wait sub-phase SHALL be ignored.
REQ-028 If SS_n rises before rx_valid, or during MISO transmission: no rx_valid, frame_err pulses one cycle, next state is IDLE, rd_addr_done unchanged.
REQ-029 SS_n rising in the same cycle as the final bit SHALL count as an abort; the final bit requires SS_n=0.
REQ-030 Counter width SHALL be $clog2(DW+CW+2) and SHALL never wrap.

Reset
REQ-031 Asserting rst SHALL immediately force state=IDLE, MISO=0, rx_data=0, rx_valid=0, frame_err=0, parity_err=0, counter=0, rd_addr_done=0.
REQ-032 Reset mid-frame or mid-transmission SHALL discard the transaction with no strobes.
REQ-033 The first frame after rst deasserts SHALL require SS_n seen high then low.

Configuration
REQ-034 Macro SPI_SLAVE_PARITY_EN defined: the frame SHALL carry one trailing even-parity bit over all DW+CW preceding bits.
REQ-035 With the macro defined, on mismatch rx_valid SHALL be suppressed, parity_err SHALL pulse one cycle, and rd_addr_done SHALL be unchanged.
REQ-036 Macro not defined: frame is DW+CW bits, no parity logic, parity_err constant 0.

Verification
REQ-037 DW=8, write frame 00_1010_0101 -> single rx_valid pulse with rx_data=10'h0A5 on the 10th bit; frame_err=0.
REQ-038 Read-address 10_0011_0000, then read-data 11_xxxx_xxxx, tx_valid with tx_data=8'h3C -> MISO sequence 0,0,1,1,1,1,0,0, then rd_addr_done=0.
REQ-039 SS_n raised after 5 bits of a write frame -> frame_err pulse, no rx_valid, FSM in IDLE.
REQ-040 rst asserted during the 4th MISO bit -> MISO=0 at once, rd_addr_done=0, next read frame goes to READ_ADD.
REQ-041 With SPI_SLAVE_PARITY_EN, frame 00_0000_0001 with parity 0 -> parity_err pulse, no rx_valid; with parity 1 -> rx_valid, rx_data=10'h001.
REQ-042 DW=16 write frame with payload 16'hBEEF -> rx_data=18'h0BEEF after 18 bits.
